// File: rtl/leg_pkg.sv
// leg_pkg: shared types and helpers for the LEG fetch sequencer.
//   COND_* : comparator opcode encodings (low nibble) of conditional jumps
//   leg_ins_t : the four instruction bytes as assembled from memory
//   leg_state_e : sequencer FSM states
//   is_cond() : true when an opcode is a conditional jump
package leg_pkg;

  localparam int COND_FLAG_BIT = 5;
  localparam int COND_LT       = 8;
  localparam int COND_LE       = 9;
  localparam int COND_GT       = 10;
  localparam int COND_GE       = 11;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] arg1;
    logic [7:0] arg2;
    logic [7:0] dest;
  } leg_ins_t;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    ISSUE     = 2'd1,
    WAIT_COND = 2'd2
  } leg_state_e;

  // Conditional jumps carry the flag bit and one of the four compare codes.
  function automatic logic is_cond(input logic [7:0] opcode);
    return opcode[COND_FLAG_BIT] &&
           (opcode[3:0] >= 4'(COND_LT)) &&
           (opcode[3:0] <= 4'(COND_GE));
  endfunction

endpackage

// File: rtl/leg_byte_fetcher.sv
// leg_byte_fetcher: reads four consecutive bytes over a byte-wide request/ack
// handshake and assembles them into one instruction.
//   clk_i, rst_ni        clock, async active-low reset
//   start_i              begin a 4-byte fetch at base_i (ignored while busy)
//   base_i               address of byte 0 (held by the caller during the fetch)
//   done_o               high in the cycle the last byte is acknowledged
//   ins_o                assembled instruction bytes (registered)
//   mem_req_o/addr_o     read request and byte address
//   mem_ack_i/rdata_i    read completion and data (ack ignored while idle)
module leg_byte_fetcher
  import leg_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic              done_o,
  output leg_ins_t          ins_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i
);

  logic       req_q;
  logic [1:0] idx_q;
  leg_ins_t   ins_q;
  logic       byte_take;

  assign byte_take  = req_q & mem_ack_i;
  assign done_o     = byte_take & (idx_q == 2'd3);
  assign mem_req_o  = req_q;
  // Address arithmetic is ADDR_W wide, so it wraps naturally at the top of memory.
  assign mem_addr_o = base_i + ADDR_W'(idx_q);
  assign ins_o      = ins_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= 1'b0;
      idx_q <= 2'd0;
      ins_q <= '0;
    end else if (!req_q) begin
      if (start_i) begin
        req_q <= 1'b1;
        idx_q <= 2'd0;
      end
    end else if (byte_take) begin
      case (idx_q)
        2'd0: ins_q.opcode <= mem_rdata_i;
        2'd1: ins_q.arg1   <= mem_rdata_i;
        2'd2: ins_q.arg2   <= mem_rdata_i;
        2'd3: ins_q.dest   <= mem_rdata_i;
      endcase
      idx_q <= idx_q + 2'd1;
      if (idx_q == 2'd3) req_q <= 1'b0;
    end
  end

endmodule

// File: rtl/leg_fetch_sequencer.sv
// leg_fetch_sequencer: fetches 4-byte LEG instructions, issues them to execute
// and chooses the next PC from the comparator result for conditional jumps.
//   clk_i, rst_ni               clock, async active-low reset
//   mem_req_o/mem_addr_o        program-memory byte read request
//   mem_ack_i/mem_rdata_i       read completion and byte
//   ins_valid_o/ins_ready_i     instruction handshake to execute
//   ins_opcode_o..ins_dest_o    instruction bytes 0..3
//   cond_valid_i/cond_taken_i   comparator result, used only in WAIT_COND
//   pc_o                        address of the current instruction
// Optional build macro LEG_BRANCH_TRACE_EN adds:
//   br_count_o (16b saturating taken-branch count), br_last_o (last taken target)
//
// state     | meaning
// FETCH     | byte fetcher reading 4 bytes at pc
// ISSUE     | ins_valid high, instruction held until execute accepts
// WAIT_COND | conditional issued, waiting for comparator result
module leg_fetch_sequencer
  import leg_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              ins_valid_o,
  input  logic              ins_ready_i,
  output logic [7:0]        ins_opcode_o,
  output logic [7:0]        ins_arg1_o,
  output logic [7:0]        ins_arg2_o,
  output logic [7:0]        ins_dest_o,
  input  logic              cond_valid_i,
  input  logic              cond_taken_i,
  output logic [ADDR_W-1:0] pc_o
`ifdef LEG_BRANCH_TRACE_EN
  ,
  output logic [15:0]       br_count_o,
  output logic [ADDR_W-1:0] br_last_o
`endif
);

  leg_state_e        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              ins_valid_q;
  logic              fetch_start;
  logic              fetch_done;
  leg_ins_t          ins;
  logic [ADDR_W-1:0] target;

  // Kick the fetcher on the first FETCH cycle; its own request flag marks it busy.
  assign fetch_start = (state_q == FETCH) && !mem_req_o;
  assign target      = ADDR_W'(ins.dest);

  leg_byte_fetcher #(.ADDR_W(ADDR_W)) u_fetch (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (fetch_start),
    .base_i     (pc_q),
    .done_o     (fetch_done),
    .ins_o      (ins),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= FETCH;
      pc_q        <= ADDR_W'(RESET_PC);
      ins_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (fetch_done) begin
            state_q     <= ISSUE;
            ins_valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (ins_ready_i) begin
            ins_valid_q <= 1'b0;
            if (is_cond(ins.opcode)) begin
              state_q <= WAIT_COND;
            end else begin
              pc_q    <= pc_q + ADDR_W'(4);
              state_q <= FETCH;
            end
          end
        end
        WAIT_COND: begin
          if (cond_valid_i) begin
            pc_q    <= cond_taken_i ? target : pc_q + ADDR_W'(4);
            state_q <= FETCH;
          end
        end
        default: begin
          state_q     <= FETCH;
          ins_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o         = pc_q;
  assign ins_valid_o  = ins_valid_q;
  assign ins_opcode_o = ins.opcode;
  assign ins_arg1_o   = ins.arg1;
  assign ins_arg2_o   = ins.arg2;
  assign ins_dest_o   = ins.dest;

`ifdef LEG_BRANCH_TRACE_EN
  logic [15:0]       br_count_q;
  logic [ADDR_W-1:0] br_last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_count_q <= 16'd0;
      br_last_q  <= ADDR_W'(RESET_PC);
    end else if ((state_q == WAIT_COND) && cond_valid_i && cond_taken_i) begin
      if (br_count_q != 16'hFFFF) br_count_q <= br_count_q + 16'd1;
      br_last_q <= target;
    end
  end

  assign br_count_o = br_count_q;
  assign br_last_o  = br_last_q;
`else
  // Trace disabled: no counter or last-target registers.
`endif

endmodule

// File: tb/tb_leg_fetch_sequencer.sv
module tb_leg_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       ins_valid;
  logic       ins_ready;
  logic [7:0] ins_opcode, ins_arg1, ins_arg2, ins_dest;
  logic       cond_valid, cond_taken;
  logic [7:0] pc;
`ifdef LEG_BRANCH_TRACE_EN
  logic [15:0] br_count;
  logic [7:0]  br_last;
`endif

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  leg_fetch_sequencer #(.ADDR_W(8), .RESET_PC(0)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .ins_valid_o (ins_valid),
    .ins_ready_i (ins_ready),
    .ins_opcode_o(ins_opcode),
    .ins_arg1_o  (ins_arg1),
    .ins_arg2_o  (ins_arg2),
    .ins_dest_o  (ins_dest),
    .cond_valid_i(cond_valid),
    .cond_taken_i(cond_taken),
    .pc_o        (pc)
`ifdef LEG_BRANCH_TRACE_EN
    ,
    .br_count_o  (br_count),
    .br_last_o   (br_last)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve nbytes reads starting at base, holding each ack off for dly cycles.
  task automatic serve(input logic [7:0] base, input int nbytes, input int dly);
    for (int b = 0; b < nbytes; b++) begin
      logic [7:0] a;
      int n;
      a = base + 8'(b);
      n = 0;
      while (!mem_req && n < 20) begin
        tick();
        n++;
      end
      chk("req_timeout", 32'(mem_req), 32'd1);
      chk("fetch_addr", 32'(mem_addr), 32'(a));
      for (int d = 0; d < dly; d++) begin
        tick();
        chk("addr_hold", 32'(mem_addr), 32'(a));
      end
      mem_ack   = 1'b1;
      mem_rdata = mem[a];
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
    end
  endtask

  task automatic chk_ins(input logic [7:0] op, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] de);
    chk("ins_valid", 32'(ins_valid), 32'd1);
    chk("mem_req_after", 32'(mem_req), 32'd0);
    chk("opcode", 32'(ins_opcode), 32'(op));
    chk("arg1", 32'(ins_arg1), 32'(a1));
    chk("arg2", 32'(ins_arg2), 32'(a2));
    chk("dest", 32'(ins_dest), 32'(de));
  endtask

  task automatic xfer();
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    chk("valid_drop", 32'(ins_valid), 32'd0);
  endtask

  task automatic cond(input logic taken);
    cond_valid = 1'b1;
    cond_taken = taken;
    tick();
    cond_valid = 1'b0;
    cond_taken = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
    ins_ready = 1'b0; cond_valid = 1'b0; cond_taken = 1'b0;
    repeat (3) tick();

    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_opcode", 32'(ins_opcode), 32'h00);
    chk("rst_dest", 32'(ins_dest), 32'h00);

    // 1: back-to-back acks
    mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h02; mem[3] = 8'h03;
    rst_n = 1'b1;
    c0 = cyc;
    serve(8'h00, 4, 0);
    chk("first_latency", 32'(cyc - c0), 32'd5);
    chk_ins(8'h00, 8'h01, 8'h02, 8'h03);
    chk("pc_hold", 32'(pc), 32'h00);
    xfer();
    chk("pc_t1", 32'(pc), 32'h04);

    // 2: slow acks
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    serve(8'h04, 4, 3);
    chk_ins(8'h11, 8'h22, 8'h33, 8'h44);
    xfer();
    chk("pc_t2", 32'(pc), 32'h08);

    // 3: conditional taken (cond_valid in transfer cycle ignored), then not taken
    mem[8] = 8'h28; mem[9] = 8'hAA; mem[10] = 8'hBB; mem[11] = 8'h40;
    serve(8'h08, 4, 0);
    chk_ins(8'h28, 8'hAA, 8'hBB, 8'h40);
    ins_ready = 1'b1; cond_valid = 1'b1; cond_taken = 1'b1;
    tick();
    ins_ready = 1'b0; cond_valid = 1'b0; cond_taken = 1'b0;
    chk("cond_early_pc", 32'(pc), 32'h08);
    tick();
    chk("wait_no_req", 32'(mem_req), 32'd0);
    chk("wait_pc", 32'(pc), 32'h08);
    cond(1'b1);
    chk("pc_taken", 32'(pc), 32'h40);
    mem[8'h40] = 8'h2B; mem[8'h41] = 8'h00; mem[8'h42] = 8'h00; mem[8'h43] = 8'h10;
    serve(8'h40, 4, 0);
    chk_ins(8'h2B, 8'h00, 8'h00, 8'h10);
    xfer();
    cond(1'b0);
    chk("pc_not_taken", 32'(pc), 32'h44);

    // 4: stalled issue, stray ack, pc wrap
    mem[8'h44] = 8'h05; mem[8'h45] = 8'h01; mem[8'h46] = 8'h02; mem[8'h47] = 8'h03;
    serve(8'h44, 4, 0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin mem_ack = 1'b1; mem_rdata = 8'hEE; end
      tick();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      chk("stall_valid", 32'(ins_valid), 32'd1);
      chk("stall_req", 32'(mem_req), 32'd0);
      chk("stall_opcode", 32'(ins_opcode), 32'h05);
      chk("stall_dest", 32'(ins_dest), 32'h03);
    end
    xfer();
    chk("pc_t4a", 32'(pc), 32'h48);
    mem[8'h48] = 8'h29; mem[8'h49] = 8'h00; mem[8'h4A] = 8'h00; mem[8'h4B] = 8'hFC;
    serve(8'h48, 4, 0);
    xfer();
    cond(1'b1);
    chk("pc_fc", 32'(pc), 32'hFC);
    mem[8'hFC] = 8'h30; mem[8'hFD] = 8'h01; mem[8'hFE] = 8'h02; mem[8'hFF] = 8'h03;
    serve(8'hFC, 4, 0);
    chk_ins(8'h30, 8'h01, 8'h02, 8'h03);
    xfer();
    chk("pc_wrap", 32'(pc), 32'h00);
    mem[0] = 8'h2A; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'hFE;
    serve(8'h00, 4, 0);
    xfer();
    cond(1'b1);
    chk("pc_fe", 32'(pc), 32'hFE);
    serve(8'hFE, 4, 0);
    chk_ins(8'h02, 8'h03, 8'h2A, 8'h00);
    xfer();
    chk("pc_wrap2", 32'(pc), 32'h02);
    mem[2] = 8'h2C;
    serve(8'h02, 4, 0);
    chk_ins(8'h2C, 8'hFE, 8'h11, 8'h22);
    xfer();
    chk("pc_nc_2c", 32'(pc), 32'h06);
    mem[6] = 8'h2B; mem[7] = 8'h33; mem[8] = 8'h28; mem[9] = 8'h06;
    serve(8'h06, 4, 0);
    xfer();
    cond(1'b1);
    chk("pc_self", 32'(pc), 32'h06);
    serve(8'h06, 4, 0);
    chk_ins(8'h2B, 8'h33, 8'h28, 8'h06);
    xfer();
    cond(1'b0);
    chk("pc_self_exit", 32'(pc), 32'h0A);
`ifdef LEG_BRANCH_TRACE_EN
    chk("br_count", 32'(br_count), 32'd4);
    chk("br_last", 32'(br_last), 32'h06);
`endif

    // 5: reset during WAIT_COND, then during FETCH byte 2
    mem[8'h0A] = 8'h28; mem[8'h0B] = 8'h00; mem[8'h0C] = 8'h00; mem[8'h0D] = 8'h80;
    serve(8'h0A, 4, 0);
    xfer();
    rst_n = 1'b0;
    #1;
    chk("rw_pc", 32'(pc), 32'h00);
    chk("rw_valid", 32'(ins_valid), 32'd0);
    chk("rw_req", 32'(mem_req), 32'd0);
    chk("rw_opcode", 32'(ins_opcode), 32'h00);
    chk("rw_dest", 32'(ins_dest), 32'h00);
`ifdef LEG_BRANCH_TRACE_EN
    chk("rw_br_count", 32'(br_count), 32'd0);
    chk("rw_br_last", 32'(br_last), 32'h00);
`endif
    tick();
    rst_n = 1'b1;
    mem[2] = 8'h2C;
    serve(8'h00, 2, 0);
    chk("mid_idx2_addr", 32'(mem_addr), 32'h02);
    rst_n = 1'b0;
    #1;
    chk("rf_req", 32'(mem_req), 32'd0);
    chk("rf_opcode", 32'(ins_opcode), 32'h00);
    chk("rf_arg1", 32'(ins_arg1), 32'h00);
    chk("rf_pc", 32'(pc), 32'h00);
    tick();
    rst_n = 1'b1;
    serve(8'h00, 4, 0);
    chk_ins(8'h2A, 8'h00, 8'h2C, 8'hFE);
    xfer();
    cond(1'b1);
    chk("pc_after_rst", 32'(pc), 32'hFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
